// File: rtl/alu_divider.sv
// Iterative restoring divider for RV32 DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional abort port enabled by defining DIV_FLUSH_EN.
module alu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_signed,
    input  logic            in_rem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
`ifdef DIV_FLUSH_EN
    ,
    input  logic            flush
`endif
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              op_rem_q, op_rem_d;

    logic              flush_w;
`ifdef DIV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic              accept;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, sgn_ovf;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   trial;
    logic              trial_ge;
    logic              unused_trial_bit;
    logic [XLEN-1:0]   fix_result;

    assign accept   = in_valid & in_ready & ~flush_w;
    assign a_neg    = in_signed & in_a[XLEN-1];
    assign b_neg    = in_signed & in_b[XLEN-1];
    assign a_mag    = a_neg ? (~in_a + 1'b1) : in_a;
    assign b_mag    = b_neg ? (~in_b + 1'b1) : in_b;
    assign div_zero = (in_b == '0);
    assign sgn_ovf  = in_signed & (in_a == MIN_NEG) & (in_b == '1);

    // Trial subtract as A + ~B + 1; the carry out of XLEN+1 bits means "no borrow".
    assign shifted          = {rem_q, quo_q[XLEN-1]};
    assign trial            = {1'b0, shifted} + {1'b0, ~{1'b0, div_q}} + (XLEN+2)'(1);
    assign trial_ge         = trial[XLEN+1];
    assign unused_trial_bit = trial[XLEN];

    always_comb begin
        fix_result = '0;
        if (op_rem_q) begin
            fix_result = rneg_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            fix_result = qneg_q ? (~quo_q + 1'b1) : quo_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (div_zero | sgn_ovf) ? DONE : CALC;
            CALC: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_w) state_d = IDLE;
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign out_data = data_q;

    // NOTE: every next-state value is defaulted to its current value first so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        data_d   = data_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        op_rem_d = op_rem_q;
        if (!flush_w) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            data_d = in_rem ? in_a : '1;
                        end else if (sgn_ovf) begin
                            data_d = in_rem ? '0 : in_a;
                        end else begin
                            cnt_d    = CNT_W'(XLEN-1);
                            rem_d    = '0;
                            quo_d    = a_mag;
                            div_d    = b_mag;
                            qneg_d   = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            op_rem_d = in_rem;
                        end
                    end
                end
                CALC: begin
                    quo_d = {quo_q[XLEN-2:0], trial_ge};
                    rem_d = trial_ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                end
                FIX:     data_d = fix_result;
                default: ;
            endcase
        end
    end

    // NOTE: datapath registers are reset too, so out_data reads 0 rather than X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            data_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            op_rem_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            data_q   <= data_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            op_rem_q <= op_rem_d;
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed RV32 corner cases plus randomized ops
// against an arithmetic reference model; flush scenario when DIV_FLUSH_EN is defined.
module tb_alu_divider;

    localparam int XLEN = 32;
    localparam int TIMEOUT = 100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            in_signed;
    logic            in_rem;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
`ifdef DIV_FLUSH_EN
    logic            flush;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [XLEN-1:0] last_result = '0;

    alu_divider #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_rem    (in_rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DIV_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : a;
        if (s) return r ? 32'(sa % sb) : 32'(sa / sb);
        return r ? a % b : a / b;
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 2;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_rem    = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full operation: accept edge counts as edge 1; bp = cycles of withheld out_ready in DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic r, input int bp);
        int edges;
        logic [31:0] exp;
        exp = ref_div(a, b, s, r);
        out_ready = 1'b0;
        start_op(a, b, s, r);
        edges = 1;
        while (!out_valid && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(ref_latency(a, b, s)));
        check({tag, " data"}, out_data, exp);
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold data"}, out_data, exp);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " idle valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle ready"}, 32'(in_ready), 32'd1);
        check({tag, " idle data"}, out_data, exp);
        last_result = exp;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs, rr;
        int          mode;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_rem    = 1'b0;
        out_ready = 1'b0;
`ifdef DIV_FLUSH_EN
        flush     = 1'b0;
`endif
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu 100/7", 32'd100, 32'd7, 1'b0, 1'b0, 0);
        run_op("remu 100/7", 32'd100, 32'd7, 1'b0, 1'b1, 0);
        run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
        run_op("rem -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0);
        run_op("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
        run_op("divu 5/0", 32'd5, 32'd0, 1'b0, 1'b0, 0);
        run_op("remu 5/0", 32'd5, 32'd0, 1'b0, 1'b1, 0);
        run_op("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        run_op("rem ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        run_op("divu min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op("div min/2", 32'h8000_0000, 32'd2, 1'b1, 1'b0, 0);
        run_op("div 0/3", 32'd0, 32'd3, 1'b1, 1'b0, 0);
        run_op("backpressure", 32'd1000, 32'd9, 1'b0, 1'b0, 5);

        // Asynchronous reset in the middle of CALC with counter at 10.
        out_ready = 1'b0;
        start_op(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("midreset no valid", 32'(out_valid), 32'd0);
        end
        run_op("divu 9/3", 32'd9, 32'd3, 1'b0, 1'b0, 0);

`ifdef DIV_FLUSH_EN
        start_op(32'd12345, 32'd11, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_data", out_data, last_result);
        repeat (XLEN + 4) begin
            @(posedge clk);
            #1;
            check("flush no valid", 32'(out_valid), 32'd0);
        end
        run_op("after flush", 32'hFFFF_FF00, 32'd3, 1'b1, 1'b1, 1);
`endif

        for (int k = 0; k < 40; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            rs   = 1'($urandom_range(0, 1));
            rr   = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 7);
            case (mode)
                0: rb = 32'd0;
                1: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: ;
            endcase
            run_op($sformatf("rand%0d", k), ra, rb, rs, rr, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
